// File: rtl/mac_accumulator_if.sv
// Handshake and data bundle between the multiplier/control side and the MAC accumulator.
// master drives job control, products and drain-ready; slave is the accumulator.
interface mac_accumulator_if #(
  parameter int WIDTH_MUL = 32,
  parameter int ACC_W     = 40,
  parameter int CNT_W     = 8
);
  logic                 start;
  logic [CNT_W-1:0]     k_len;
  logic                 in_valid;
  logic [WIDTH_MUL-1:0] prod_in;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     acc_out;
  logic                 ovf;
  logic                 busy;

  modport master (
    output start, k_len, in_valid, prod_in, out_ready,
    input  in_ready, out_valid, acc_out, ovf, busy
  );

  modport slave (
    input  start, k_len, in_valid, prod_in, out_ready,
    output in_ready, out_valid, acc_out, ovf, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulates K multiplier products into a wide register with optional saturation.
// Result valid the cycle after the last accept; in_ready stalls the multiplier outside ACC.
module mac_accumulator #(
  parameter int WIDTH_MUL = 32,
  parameter int ACC_W     = 40,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1,
  parameter int CNT_W     = 8
) (
  input logic              clk,
  input logic              rst_n,
  mac_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W-1:0] acc_sum;

  // One guard bit above the accumulator exposes both signed and unsigned overflow.
  always_comb begin
    prod_ext = '0;
    sum      = '0;
    sum_ovf  = 1'b0;
    sat_val  = '1;
    if (SIGNED != 0) begin
      prod_ext = ACC_W'($signed(bus.prod_in));
      sum      = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
      sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val  = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      prod_ext = ACC_W'(bus.prod_in);
      sum      = {1'b0, acc} + {1'b0, prod_ext};
      sum_ovf  = sum[ACC_W];
      sat_val  = '1;
    end
    acc_sum = (sum_ovf && (SATURATE != 0)) ? sat_val : sum[ACC_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = bus.k_len;
          state_nxt = (bus.k_len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_nxt = acc_sum;
          ovf_nxt = ovf | sum_ovf;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        // A start during the drain handshake chains straight into the next job.
        if (bus.out_ready) begin
          if (bus.start) begin
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = bus.k_len;
            state_nxt = (bus.k_len == '0) ? DONE : ACC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Drives four accumulator configurations with shared stimulus and scoreboards every drained result.
module tb_mac_accumulator;

  localparam int SG [4] = '{0, 1, 1, 1};
  localparam int AW [4] = '{40, 40, 32, 32};
  localparam int ST [4] = '{1, 1, 1, 0};

  typedef struct packed {
    logic [3:0][39:0] acc;
    logic [3:0]       ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  k_len;
  logic        in_valid;
  logic [31:0] prod_in;
  logic        out_ready;

  logic [31:0] pv [8];
  res_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_push = 0;
  int          n_pop = 0;

  always #5 clk = ~clk;

  mac_accumulator_if #(.WIDTH_MUL(32), .ACC_W(40), .CNT_W(8)) if0 ();
  mac_accumulator_if #(.WIDTH_MUL(32), .ACC_W(40), .CNT_W(8)) if1 ();
  mac_accumulator_if #(.WIDTH_MUL(32), .ACC_W(32), .CNT_W(8)) if2 ();
  mac_accumulator_if #(.WIDTH_MUL(32), .ACC_W(32), .CNT_W(8)) if3 ();

  assign {if0.start, if1.start, if2.start, if3.start} = {4{start}};
  assign {if0.in_valid, if1.in_valid, if2.in_valid, if3.in_valid} = {4{in_valid}};
  assign {if0.out_ready, if1.out_ready, if2.out_ready, if3.out_ready} = {4{out_ready}};
  assign if0.k_len = k_len;
  assign if1.k_len = k_len;
  assign if2.k_len = k_len;
  assign if3.k_len = k_len;
  assign if0.prod_in = prod_in;
  assign if1.prod_in = prod_in;
  assign if2.prod_in = prod_in;
  assign if3.prod_in = prod_in;

  mac_accumulator #(.WIDTH_MUL(32), .ACC_W(40), .SIGNED(0), .SATURATE(1), .CNT_W(8))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mac_accumulator #(.WIDTH_MUL(32), .ACC_W(40), .SIGNED(1), .SATURATE(1), .CNT_W(8))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mac_accumulator #(.WIDTH_MUL(32), .ACC_W(32), .SIGNED(1), .SATURATE(1), .CNT_W(8))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mac_accumulator #(.WIDTH_MUL(32), .ACC_W(32), .SIGNED(1), .SATURATE(0), .CNT_W(8))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic [3:0][39:0] acc_v;
  logic [3:0]       ovf_v;
  assign acc_v = {{8'h0, if3.acc_out}, {8'h0, if2.acc_out}, if1.acc_out, if0.acc_out};
  assign ovf_v = {if3.ovf, if2.ovf, if1.ovf, if0.ovf};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic on 64-bit integers: exact sum, then range test per configuration.
  task automatic push_expect(input int k);
    res_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      longint a = 0, p, s, span, hi, lo;
      bit     o = 1'b0;
      span = longint'(1) << AW[c];
      hi   = (SG[c] != 0) ? (span >>> 1) - 1 : span - 1;
      lo   = (SG[c] != 0) ? -(span >>> 1) : 0;
      for (int i = 0; i < k; i++) begin
        p = (SG[c] != 0) ? longint'($signed(pv[i])) : longint'(pv[i]);
        s = a + p;
        if (s > hi) begin
          o = 1'b1;
          a = (ST[c] != 0) ? hi : s - span;
        end else if (s < lo) begin
          o = 1'b1;
          a = (ST[c] != 0) ? lo : s + span;
        end else begin
          a = s;
        end
      end
      r.acc[c] = 40'(a & (span - 1));
      r.ovf[c] = o;
    end
    exp_q.push_back(r);
    n_push++;
  endtask

  // Starts from IDLE, feeds pv[0..k-1] with 'gap' bubbles between products; ends in DONE.
  task automatic run_job(input int k, input int gap);
    push_expect(k);
    start = 1'b1;
    k_len = 8'(k);
    cyc();
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (i > 0) repeat (gap) cyc();
      if (i == k - 1) chk("pre_done_vld", {63'b0, if0.out_valid}, 64'd0);
      in_valid = 1'b1;
      prod_in  = pv[i];
      cyc();
      in_valid = 1'b0;
    end
    chk("done_vld", {63'b0, if0.out_valid}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && if0.out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("q_underflow", 64'd1, 64'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        n_pop++;
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("acc%0d", c), {24'b0, acc_v[c]}, {24'b0, r.acc[c]});
          chk($sformatf("ovf%0d", c), {63'b0, ovf_v[c]}, {63'b0, r.ovf[c]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; prod_in = '0; out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_vld",  {63'b0, if0.out_valid}, 64'd0);
    chk("rst_rdy",  {63'b0, if0.in_ready}, 64'd0);
    chk("rst_busy", {63'b0, if0.busy}, 64'd0);
    chk("rst_acc",  {24'b0, if0.acc_out}, 64'd0);
    chk("rst_ovf",  {63'b0, if0.ovf}, 64'd0);

    // Products offered in IDLE must not be consumed.
    in_valid = 1'b1; prod_in = 32'd99;
    cyc();
    chk("idle_busy", {63'b0, if0.busy}, 64'd0);
    chk("idle_rdy",  {63'b0, if0.in_ready}, 64'd0);
    in_valid = 1'b0;

    pv[0] = 32'd5; pv[1] = 32'd7; pv[2] = 32'd11;
    run_job(3, 0);
    chk("done_rdy", {63'b0, if0.in_ready}, 64'd0);
    chk("done_acc", {24'b0, if0.acc_out}, 64'd23);
    cyc();

    pv[0] = 32'h7FFF_FFFF; pv[1] = 32'h8000_0000;
    run_job(2, 0); cyc();
    pv[0] = 32'h7FFF_FFFF; pv[1] = 32'h0000_0001;
    run_job(2, 0); cyc();
    pv[0] = 32'h8000_0000; pv[1] = 32'h8000_0000;
    run_job(2, 0); cyc();
    pv[0] = 32'h7FFF_FFFF; pv[1] = 32'h0000_0001; pv[2] = 32'hFFFF_FFFF;
    run_job(3, 0); cyc();

    // Empty job straight to DONE, also clearing the sticky flag left above.
    run_job(0, 0);
    chk("k0_acc", {24'b0, if0.acc_out}, 64'd0);
    cyc();

    out_ready = 1'b0;
    pv[0] = 32'h7FFF_FFFF; pv[1] = 32'h0000_0001;
    run_job(2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_vld",  {63'b0, if0.out_valid}, 64'd1);
      chk("hold_acc",  {24'b0, if0.acc_out}, 64'h8000_0000);
      chk("hold_acc2", {32'b0, if2.acc_out}, 64'h7FFF_FFFF);
      chk("hold_ovf2", {63'b0, if2.ovf}, 64'd1);
      cyc();
    end
    pv[0] = 32'd9;
    push_expect(1);
    out_ready = 1'b1; start = 1'b1; k_len = 8'd1;
    cyc();
    start = 1'b0;
    chk("chain_rdy", {63'b0, if0.in_ready}, 64'd1);
    chk("chain_vld", {63'b0, if0.out_valid}, 64'd0);
    chk("chain_ovf2", {63'b0, if2.ovf}, 64'd0);
    in_valid = 1'b1; prod_in = 32'd9;
    cyc();
    in_valid = 1'b0;
    chk("chain_done", {63'b0, if0.out_valid}, 64'd1);
    cyc();

    // Bubbles between products, with a stray start that must be ignored in ACC.
    pv[0] = 32'd100; pv[1] = 32'd200;
    push_expect(2);
    start = 1'b1; k_len = 8'd2;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; prod_in = pv[0];
    cyc();
    in_valid = 1'b0; start = 1'b1; k_len = 8'd7;
    chk("gap_rdy", {63'b0, if0.in_ready}, 64'd1);
    cyc();
    start = 1'b0;
    cyc();
    in_valid = 1'b1; prod_in = pv[1];
    cyc();
    in_valid = 1'b0;
    chk("gap_done", {63'b0, if0.out_valid}, 64'd1);
    chk("gap_acc",  {24'b0, if0.acc_out}, 64'd300);
    cyc();

    // Abort a K=4 job after two products.
    start = 1'b1; k_len = 8'd4;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; prod_in = 32'h7FFF_FFFF;
    cyc();
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("abort_vld",  {63'b0, if0.out_valid}, 64'd0);
    chk("abort_busy", {63'b0, if0.busy}, 64'd0);
    chk("abort_acc",  {24'b0, if0.acc_out}, 64'd0);
    chk("abort_ovf2", {63'b0, if2.ovf}, 64'd0);
    pv[0] = 32'd3;
    run_job(1, 0);
    chk("post_abort_acc", {24'b0, if0.acc_out}, 64'd3);
    repeat (3) cyc();

    chk("q_drain", 64'(exp_q.size()), 64'd0);
    chk("n_results", 64'(n_pop), 64'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
